load_store_unit: RTL and testbench

MEM-stage load/store initiator of the pipelined RISC-V core. Accepts a memory operation from the EX/MEM register (MemRead/MemWrite, Funct3, ALU address, store data), drives a word-organised data-memory port with byte enables and a req/ack handshake, and returns aligned, sign- or zero-extended load data. Stalls the pipeline while the access is outstanding. Flags misaligned, illegal-funct3 and timed-out accesses instead of issuing them.

---
 rtl/load_store_unit.sv | 199 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: issues word-organised data-memory accesses
// over a req/ack handshake, extends load data and stalls the pipeline while
// an access is outstanding. Illegal, misaligned and timed-out accesses are
// reported with err instead of being issued.
module load_store_unit #(
   parameter int unsigned DM_ADDRESS  = 9,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [2:0]            Funct3,
   input  logic [DATA_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wd,
   output logic                  stall,
   output logic                  rd_valid,
   output logic [DATA_W-1:0]     rd,
   output logic                  err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [DM_ADDRESS-1:0] mem_addr,
   output logic [3:0]            mem_be,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_W-1:0]     mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

   state_e                state_q, state_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [DM_ADDRESS-1:0] mem_addr_q, mem_addr_d;
   logic [3:0]            mem_be_q, mem_be_d;
   logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
   logic [1:0]            off_q, off_d;
   logic [2:0]            f3_q, f3_d;
   logic                  load_q, load_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [DATA_W-1:0]     rd_q, rd_d;
   logic                  err_q, err_d;

   logic                  op, is_load, f3_legal, misaligned;
   logic [3:0]            st_be;
   logic [DATA_W-1:0]     st_wdata;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [DATA_W-1:0]     ld_data;
   logic                  unused_addr;

   assign unused_addr = ^addr[DATA_W-1:DM_ADDRESS];

   // Decode the incoming request: legality, alignment and store lane encoding
   always_comb begin
      op      = req_valid & (MemRead | MemWrite);
      is_load = MemRead;
      if (is_load) begin
         f3_legal = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                    (Funct3 == 3'b100) || (Funct3 == 3'b101);
      end else begin
         f3_legal = (Funct3 == 3'b000) || (Funct3 == 3'b001) || (Funct3 == 3'b010);
      end
      misaligned = ((Funct3[1:0] == 2'b01) && addr[0]) ||
                   ((Funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      case (Funct3[1:0])
         2'b00: begin
            st_be    = 4'b0001 << addr[1:0];
            st_wdata = {4{wd[7:0]}};
         end
         2'b01: begin
            st_be    = addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{wd[15:0]}};
         end
         default: begin
            st_be    = 4'b1111;
            st_wdata = wd;
         end
      endcase
   end

   // Select and extend the returned word using the registered offset/funct3
   always_comb begin
      ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
      ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b010:  ld_data = mem_rdata;
         3'b100:  ld_data = {24'b0, ld_byte};
         3'b101:  ld_data = {16'b0, ld_half};
         default: ld_data = '0;
      endcase
   end

   // Next-state logic: accept/reject in IDLE, watchdog in ACCESS, one-cycle RESP
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      off_d       = off_q;
      f3_d        = f3_q;
      load_d      = load_q;
      cnt_d       = cnt_q;
      rd_d        = rd_q;
      err_d       = err_q;
      case (state_q)
         IDLE: begin
            rd_d  = '0;
            err_d = 1'b0;
            if (op) begin
               if (!f3_legal || misaligned) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = ~is_load;
                  mem_addr_d  = {addr[DM_ADDRESS-1:2], 2'b00};
                  mem_be_d    = is_load ? 4'b0000 : st_be;
                  mem_wdata_d = is_load ? '0 : st_wdata;
                  off_d       = addr[1:0];
                  f3_d        = Funct3;
                  load_d      = is_load;
                  cnt_d       = '0;
                  state_d     = ACCESS;
               end
            end
         end
         ACCESS: begin
            // An ack in the final watchdog cycle still completes the access
            if (mem_ack) begin
               mem_req_d = 1'b0;
               rd_d      = load_q ? ld_data : '0;
               err_d     = 1'b0;
               state_d   = RESP;
            end else if (cnt_q == CNT_LAST) begin
               mem_req_d = 1'b0;
               rd_d      = '0;
               err_d     = 1'b1;
               state_d   = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered memory-port/result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         off_q       <= '0;
         f3_q        <= '0;
         load_q      <= 1'b0;
         cnt_q       <= '0;
         rd_q        <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         off_q       <= off_d;
         f3_q        <= f3_d;
         load_q      <= load_d;
         cnt_q       <= cnt_d;
         rd_q        <= rd_d;
         err_q       <= err_d;
      end
   end

   assign stall     = op & (state_q != RESP);
   assign rd_valid  = (state_q == RESP);
   assign rd        = rd_q;
   assign err       = err_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed tables and random
// back-to-back traffic checked against a byte-level behavioural model.
module tb_load_store_unit;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, MemRead, MemWrite;
   logic [2:0]  Funct3;
   logic [31:0] addr, wd;
   logic        stall, rd_valid, err;
   logic [31:0] rd;
   logic        mem_req, mem_we;
   logic [8:0]  mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int          req_cnt;
      int          rv_cyc;
      int          stall_cnt;
      logic [8:0]  maddr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] rd;
      logic        err;
      logic        bad_proto;
   } obs_t;

   always #5 clk = ~clk;

   load_store_unit #(.DM_ADDRESS(9), .DATA_W(32), .ACK_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .MemRead(MemRead),
      .MemWrite(MemWrite), .Funct3(Funct3), .addr(addr), .wd(wd),
      .stall(stall), .rd_valid(rd_valid), .rd(rd), .err(err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   // Expected transaction outcome from the ISA rules; lat=0 means never acked
   function automatic obs_t model(input logic rdn, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] d, input logic [31:0] rdata, input int lat);
      obs_t        e;
      int          size, ofs;
      logic        bad;
      logic [31:0] mask, v;
      size = 1 << f3[1:0];
      ofs  = int'(a % 4);
      if (rdn) bad = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      else     bad = (f3 > 2);
      if (!bad && (ofs % size) != 0) bad = 1'b1;
      e.bad_proto = 1'b0;
      e.maddr = '0; e.be = '0; e.we = 1'b0; e.wdata = '0; e.rd = '0; e.err = 1'b0;
      if (bad) begin
         e.req_cnt = 0; e.rv_cyc = 1; e.stall_cnt = 1; e.err = 1'b1;
         return e;
      end
      e.maddr = 9'((a % 512) / 4 * 4);
      e.we    = !rdn;
      if (!rdn) begin
         e.be = 4'(((1 << size) - 1) << ofs);
         for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = d[8*(i % size) +: 8];
      end
      if (lat == 0) begin
         e.req_cnt = TO; e.rv_cyc = TO + 1; e.stall_cnt = TO + 1; e.err = 1'b1;
      end else begin
         e.req_cnt = lat; e.rv_cyc = lat + 1; e.stall_cnt = lat + 1;
         if (rdn) begin
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
            v    = (rdata >> (8 * ofs)) & mask;
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
            e.rd = v;
         end
      end
      return e;
   endfunction

   // Drives one request as the pipeline would and acts as the memory; records what happened
   task automatic run_op(input logic rdn, input logic wrn, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdata,
                         input int lat, output obs_t o);
      int cyc;
      o.req_cnt = 0; o.rv_cyc = -1; o.stall_cnt = 0; o.maddr = '0; o.be = '0;
      o.we = 1'b0; o.wdata = '0; o.rd = '0; o.err = 1'b0; o.bad_proto = 1'b0;
      req_valid = 1'b1; MemRead = rdn; MemWrite = wrn; Funct3 = f3; addr = a; wd = d;
      mem_ack = 1'b0; mem_rdata = rdata;
      #1;
      cyc = 0;
      if (stall) o.stall_cnt++;
      while (o.rv_cyc < 0 && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
         mem_ack = 1'b0;
         if (stall) o.stall_cnt++;
         if (rd_valid) begin
            o.rv_cyc = cyc; o.rd = rd; o.err = err;
            if (mem_req) o.bad_proto = 1'b1;
         end else if (mem_req) begin
            o.req_cnt++;
            if (o.req_cnt == 1) begin
               o.maddr = mem_addr; o.be = mem_be; o.we = mem_we; o.wdata = mem_wdata;
            end else if (mem_addr !== o.maddr || mem_be !== o.be || mem_we !== o.we ||
                         mem_wdata !== o.wdata) begin
               o.bad_proto = 1'b1;
            end
            if (lat > 0 && o.req_cnt == lat) mem_ack = 1'b1;
         end
      end
      @(posedge clk); #1;
      if (rd_valid) o.bad_proto = 1'b1;
      req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = '0;
      addr = '0; wd = '0; mem_ack = 1'b0; mem_rdata = '0;
      #3;
      checks++;
      if ({mem_req, mem_we, rd_valid, err, stall} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctrl: got=%b exp=00000", {mem_req, mem_we, rd_valid, err, stall});
      end
      checks++;
      if ({mem_addr, mem_be, mem_wdata, rd} !== '0) begin
         failures++;
         $display("FAIL reset_data: addr=%h be=%b wdata=%h rd=%h exp all zero", mem_addr, mem_be, mem_wdata, rd);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_store();
      logic [2:0]  f3s [4];
      logic [31:0] as  [4];
      logic [31:0] ds  [4];
      int          lats[4];
      obs_t o, e;
      f3s = '{3'd2, 3'd0, 3'd1, 3'd0};
      as  = '{32'h10, 32'h13, 32'h12, 32'h10};
      ds  = '{32'hDEADBEEF, 32'h000000A5, 32'h1234ABCD, 32'h5A5A5A3C};
      lats = '{1, 2, 1, 3};
      for (int i = 0; i < 4; i++) begin
         run_op(1'b0, 1'b1, f3s[i], as[i], ds[i], 32'hFFFF_FFFF, lats[i], o);
         e = model(1'b0, f3s[i], as[i], ds[i], 32'hFFFF_FFFF, lats[i]);
         checks++;
         if ({o.req_cnt, o.rv_cyc, o.stall_cnt} !== {e.req_cnt, e.rv_cyc, e.stall_cnt}) begin
            failures++;
            $display("FAIL store%0d timing: req/rv/stall got=%0d/%0d/%0d exp=%0d/%0d/%0d", i,
                     o.req_cnt, o.rv_cyc, o.stall_cnt, e.req_cnt, e.rv_cyc, e.stall_cnt);
         end
         checks++;
         if ({o.maddr, o.be, o.we, o.wdata} !== {e.maddr, e.be, e.we, e.wdata}) begin
            failures++;
            $display("FAIL store%0d port: addr=%h be=%b we=%b wdata=%h exp addr=%h be=%b we=%b wdata=%h", i,
                     o.maddr, o.be, o.we, o.wdata, e.maddr, e.be, e.we, e.wdata);
         end
         checks++;
         if ({o.rd, o.err, o.bad_proto} !== {e.rd, e.err, 1'b0}) begin
            failures++;
            $display("FAIL store%0d result: rd=%h err=%b proto_err=%b exp rd=%h err=%b proto_err=0", i,
                     o.rd, o.err, o.bad_proto, e.rd, e.err);
         end
      end
   endtask

   task automatic test_load();
      logic [2:0]  f3s [5];
      logic [31:0] as  [5];
      int          lats[5];
      obs_t o, e;
      f3s  = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
      as   = '{32'h3, 32'h3, 32'h2, 32'h0, 32'h0};
      lats = '{1, 2, 3, 1, 4};
      for (int i = 0; i < 5; i++) begin
         run_op(1'b1, 1'b0, f3s[i], as[i], 32'hCAFEF00D, 32'h80F27F01, lats[i], o);
         e = model(1'b1, f3s[i], as[i], 32'hCAFEF00D, 32'h80F27F01, lats[i]);
         checks++;
         if ({o.req_cnt, o.rv_cyc, o.stall_cnt} !== {e.req_cnt, e.rv_cyc, e.stall_cnt}) begin
            failures++;
            $display("FAIL load%0d timing: req/rv/stall got=%0d/%0d/%0d exp=%0d/%0d/%0d", i,
                     o.req_cnt, o.rv_cyc, o.stall_cnt, e.req_cnt, e.rv_cyc, e.stall_cnt);
         end
         checks++;
         if ({o.maddr, o.be, o.we} !== {e.maddr, e.be, e.we}) begin
            failures++;
            $display("FAIL load%0d port: addr=%h be=%b we=%b exp addr=%h be=%b we=%b", i,
                     o.maddr, o.be, o.we, e.maddr, e.be, e.we);
         end
         checks++;
         if ({o.rd, o.err, o.bad_proto} !== {e.rd, e.err, 1'b0}) begin
            failures++;
            $display("FAIL load%0d result: rd=%h err=%b proto_err=%b exp rd=%h err=%b proto_err=0", i,
                     o.rd, o.err, o.bad_proto, e.rd, e.err);
         end
      end
   endtask

   task automatic test_error();
      logic        rds [6];
      logic [2:0]  f3s [6];
      logic [31:0] as  [6];
      obs_t o, e;
      rds = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      f3s = '{3'd2, 3'd3, 3'd2, 3'd4, 3'd6, 3'd1};
      as  = '{32'h12, 32'h20, 32'h11, 32'h20, 32'h24, 32'h21};
      for (int i = 0; i < 6; i++) begin
         run_op(rds[i], !rds[i], f3s[i], as[i], 32'h11223344, 32'h55667788, 1, o);
         e = model(rds[i], f3s[i], as[i], 32'h11223344, 32'h55667788, 1);
         checks++;
         if ({o.req_cnt, o.rv_cyc, o.stall_cnt} !== {e.req_cnt, e.rv_cyc, e.stall_cnt}) begin
            failures++;
            $display("FAIL error%0d timing: req/rv/stall got=%0d/%0d/%0d exp=%0d/%0d/%0d", i,
                     o.req_cnt, o.rv_cyc, o.stall_cnt, e.req_cnt, e.rv_cyc, e.stall_cnt);
         end
         checks++;
         if ({o.rd, o.err, o.bad_proto} !== {e.rd, e.err, 1'b0}) begin
            failures++;
            $display("FAIL error%0d result: rd=%h err=%b proto_err=%b exp rd=%h err=%b proto_err=0", i,
                     o.rd, o.err, o.bad_proto, e.rd, e.err);
         end
      end
   endtask

   task automatic test_timeout();
      obs_t o, e;
      for (int i = 0; i < 2; i++) begin
         run_op(i == 0, i != 0, 3'd2, 32'h40, 32'h0BADF00D, 32'h12345678, 0, o);
         e = model(i == 0, 3'd2, 32'h40, 32'h0BADF00D, 32'h12345678, 0);
         checks++;
         if ({o.req_cnt, o.rv_cyc, o.stall_cnt} !== {e.req_cnt, e.rv_cyc, e.stall_cnt}) begin
            failures++;
            $display("FAIL timeout%0d timing: req/rv/stall got=%0d/%0d/%0d exp=%0d/%0d/%0d", i,
                     o.req_cnt, o.rv_cyc, o.stall_cnt, e.req_cnt, e.rv_cyc, e.stall_cnt);
         end
         checks++;
         if ({o.rd, o.err, o.bad_proto} !== {e.rd, e.err, 1'b0}) begin
            failures++;
            $display("FAIL timeout%0d result: rd=%h err=%b proto_err=%b exp rd=%h err=%b proto_err=0", i,
                     o.rd, o.err, o.bad_proto, e.rd, e.err);
         end
         // A late ack arriving in IDLE must not produce anything
         mem_ack = 1'b1;
         for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({rd_valid, mem_req, stall} !== 3'b000) begin
               failures++;
               $display("FAIL late_ack%0d: rd_valid/mem_req/stall got=%b exp=000", c, {rd_valid, mem_req, stall});
            end
         end
         mem_ack = 1'b0;
      end
   endtask

   task automatic test_reset_mid_access();
      obs_t o, e;
      req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Funct3 = 3'd2;
      addr = 32'h20; wd = 32'hA1B2C3D4; mem_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (mem_req !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_pre: mem_req got=%b exp=1", mem_req);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_req, rd_valid, err, mem_be} !== 7'b0) begin
         failures++;
         $display("FAIL rst_mid_async: req/rv/err/be got=%b exp=0000000", {mem_req, rd_valid, err, mem_be});
      end
      req_valid = 1'b0; MemWrite = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_stall: stall got=%b exp=0", stall);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 2, o);
      e = model(1'b0, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 2);
      checks++;
      if ({o.req_cnt, o.rv_cyc, o.stall_cnt, o.maddr, o.be, o.wdata, o.err} !==
          {e.req_cnt, e.rv_cyc, e.stall_cnt, e.maddr, e.be, e.wdata, e.err}) begin
         failures++;
         $display("FAIL rst_mid_after: req=%0d rv=%0d stall=%0d addr=%h be=%b wdata=%h err=%b exp req=%0d rv=%0d stall=%0d addr=%h be=%b wdata=%h err=%b",
                  o.req_cnt, o.rv_cyc, o.stall_cnt, o.maddr, o.be, o.wdata, o.err,
                  e.req_cnt, e.rv_cyc, e.stall_cnt, e.maddr, e.be, e.wdata, e.err);
      end
   endtask

   task automatic test_back_to_back();
      obs_t        o, e;
      logic        rdn, wrn;
      logic [2:0]  f3;
      logic [31:0] a, d, rdata;
      int          lat, kind;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            req_valid = 1'b0; MemRead = 1'b1; MemWrite = 1'b1; Funct3 = 3'd2; addr = 32'h0;
            #1;
            checks++;
            if (stall !== 1'b0) begin
               failures++;
               $display("FAIL bubble%0d_stall: got=%b exp=0", i, stall);
            end
            @(posedge clk); #1;
            checks++;
            if ({mem_req, rd_valid} !== 2'b00) begin
               failures++;
               $display("FAIL bubble%0d_idle: mem_req/rd_valid got=%b exp=00", i, {mem_req, rd_valid});
            end
         end
         kind  = $urandom_range(0, 2);
         rdn   = (kind != 1);
         wrn   = (kind != 0);
         f3    = 3'($urandom_range(0, 7));
         a     = $urandom;
         if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
         d     = $urandom;
         rdata = $urandom;
         lat   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
         run_op(rdn, wrn, f3, a, d, rdata, lat, o);
         e = model(rdn, f3, a, d, rdata, lat);
         checks++;
         if ({o.req_cnt, o.rv_cyc, o.stall_cnt} !== {e.req_cnt, e.rv_cyc, e.stall_cnt}) begin
            failures++;
            $display("FAIL rnd%0d timing: req/rv/stall got=%0d/%0d/%0d exp=%0d/%0d/%0d", i,
                     o.req_cnt, o.rv_cyc, o.stall_cnt, e.req_cnt, e.rv_cyc, e.stall_cnt);
         end
         checks++;
         if ({o.maddr, o.be, o.we} !== {e.maddr, e.be, e.we}) begin
            failures++;
            $display("FAIL rnd%0d port: addr=%h be=%b we=%b exp addr=%h be=%b we=%b", i,
                     o.maddr, o.be, o.we, e.maddr, e.be, e.we);
         end
         if (e.we && e.req_cnt > 0) begin
            checks++;
            if (o.wdata !== e.wdata) begin
               failures++;
               $display("FAIL rnd%0d wdata: got=%h exp=%h", i, o.wdata, e.wdata);
            end
         end
         checks++;
         if ({o.rd, o.err, o.bad_proto} !== {e.rd, e.err, 1'b0}) begin
            failures++;
            $display("FAIL rnd%0d result: rd=%h err=%b proto_err=%b exp rd=%h err=%b proto_err=0", i,
                     o.rd, o.err, o.bad_proto, e.rd, e.err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_error();
      test_timeout();
      test_reset_mid_access();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
